imem_stream_loader: RTL and testbench

- Hardware program loader: the write side of instruction-memory initialisation.
- Accepts a byte stream over a valid/ready handshake and assembles MSB-first 32-bit words.
- Writes the words sequentially into the instruction-memory write port while holding the single-cycle CPU in reset.
- After the last word, holds the CPU in reset for a fixed number of cycles, then releases it.

---
 rtl/imem_stream_loader_if.sv | 10 +
 rtl/imem_stream_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_stream_loader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_stream_loader_if.sv
// Byte-stream valid/ready handshake feeding imem_stream_loader.
// master drives bytes, slave (the loader) returns in_ready.
interface imem_stream_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_stream_loader.sv
// Program loader: assembles MSB-first bytes into words, writes them to instruction
// memory and sequences cpu_reset. Define LOADER_CHECKSUM_EN for the trailing-sum check.
module imem_stream_loader #(
    parameter int ADDR_W     = 8,
    parameter int MEM_WORDS  = 256,
    parameter int RESET_HOLD = 3
) (
    input  logic                clk,
    input  logic                reset,
    imem_stream_loader_if.slave s_in,
    input  logic                reload,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int HOLD_W = $clog2(RESET_HOLD + 2);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_ERR  = 3'd4,
        S_CSUM = 3'd5
`else
        S_ERR  = 3'd4
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_HOLD;
`endif

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:8]         asm_q, asm_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic                in_phase;
    logic                accept;
    logic                word_done;
    logic [31:0]         full_word;
    logic [ADDR_W:0]     wl_inc;

    assign full_word = {asm_q, s_in.in_data};
    assign wl_inc    = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
    assign accept    = s_in.in_valid && in_phase;
    assign word_done = accept && (byte_cnt_q == 2'd3);

    always_comb begin
        in_phase = 1'b0;
        case (state_q)
`ifdef LOADER_CHECKSUM_EN
            S_HDR, S_DATA, S_CSUM: in_phase = 1'b1;
`else
            S_HDR, S_DATA:         in_phase = 1'b1;
`endif
            default:               in_phase = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        count_d        = count_q;
        words_loaded_d = words_loaded_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        hold_cnt_d     = hold_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d          = sum_q;
`endif

        // Lanes 0..2 are buffered; lane 3 is taken straight from in_data on completion.
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[31:24] = s_in.in_data;
                2'd1:    asm_d[23:16] = s_in.in_data;
                2'd2:    asm_d[15:8]  = s_in.in_data;
                default: ;
            endcase
        end

        case (state_q)
            S_HDR: begin
                if (word_done) begin
                    count_d = full_word[ADDR_W:0];
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = full_word;
`endif
                    if (full_word > 32'(MEM_WORDS))  state_d = S_ERR;
                    else if (full_word == 32'd0)      state_d = S_AFTER_DATA;
                    else                              state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_done) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = words_loaded_q[ADDR_W-1:0];
                    mem_wdata_d    = full_word;
                    words_loaded_d = wl_inc;
`ifdef LOADER_CHECKSUM_EN
                    sum_d          = sum_q + full_word;
`endif
                    if (wl_inc == count_q) state_d = S_AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_done) state_d = (full_word == sum_q) ? S_HOLD : S_ERR;
            end
`endif
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RESET_HOLD)) begin
                    hold_cnt_d = '0;
                    state_d    = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN, S_ERR: begin
                // in_ready is low here, so a byte offered alongside reload is never taken.
                if (reload) begin
                    state_d        = S_HDR;
                    words_loaded_d = '0;
                    byte_cnt_d     = '0;
                    hold_cnt_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d          = '0;
`endif
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_HDR;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            count_q        <= '0;
            words_loaded_q <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            hold_cnt_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            count_q        <= count_d;
            words_loaded_q <= words_loaded_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            hold_cnt_q     <= hold_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign s_in.in_ready = in_phase;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_reset     = (state_q != S_RUN);
    assign load_done     = (state_q == S_RUN);
    assign load_error    = (state_q == S_ERR);
    assign words_loaded  = words_loaded_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: table of loads, hand-written reset/reload/checksum
// sequences and randomized programs checked against a queue-based program model.
`timescale 1ns/1ps
module tb_imem_stream_loader;
    localparam int ADDR_W     = 8;
    localparam int MEM_WORDS  = 256;
    localparam int RESET_HOLD = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              reload = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset, load_done, load_error;
    logic [ADDR_W:0]   words_loaded;

    imem_stream_loader_if s_if();

    imem_stream_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .RESET_HOLD(RESET_HOLD)) dut (
        .clk(clk), .reset(reset), .s_in(s_if), .reload(reload),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every cycle with mem_we high is logged with its cycle number.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_cyc_q[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_acc = 0;
    logic [31:0] prog_q[$];
    logic [31:0] exp_w[$];

    typedef struct packed {
        int              nw;
        logic [3:0][31:0] w;
        int              gap;
        logic            exp_done;
        logic            exp_err;
        int              exp_loaded;
    } vec_t;
    vec_t tbl[5];

    function automatic vec_t mk(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input int gap,
                                input logic d, input logic e, input int ld);
        vec_t v;
        v.nw = nw; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gap = gap; v.exp_done = d; v.exp_err = e; v.exp_loaded = ld;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on the DUT", nm);
    endtask

    // Reference model: header N, then N words written to addresses 0..N-1; with the
    // checksum build, one trailing word must equal the wrapping sum of header+data.
    task automatic model(output bit d, output bit e, output int ld);
        logic [31:0] n;
        d = 1'b0; e = 1'b0; ld = 0;
        exp_w.delete();
        n = prog_q[0];
        if (n > MEM_WORDS) begin
            e = 1'b1;
            return;
        end
        for (int i = 1; i <= int'(n); i++) exp_w.push_back(prog_q[i]);
        ld = int'(n);
        d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [31:0] s;
            s = 32'd0;
            for (int i = 0; i <= int'(n); i++) s += prog_q[i];
            if (prog_q[int'(n) + 1] != s) begin d = 1'b0; e = 1'b1; end
        end
`endif
    endtask

    task automatic add_trailer();
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s;
        s = 32'd0;
        if (prog_q[0] <= MEM_WORDS) begin
            foreach (prog_q[i]) s += prog_q[i];
            prog_q.push_back(s);
        end
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        for (int tries = 0; tries < 200; tries++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                s_if.in_valid = 1'b0;
                s_if.in_data  = 8'($urandom);
            end else begin
                s_if.in_valid = 1'b1;
                s_if.in_data  = b;
                if (s_if.in_ready === 1'b1) begin
                    last_acc = cyc;
                    return;
                end
            end
        end
        timeout_fail("handshake");
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_if.in_valid = 1'b0;
        reload = 1'b0;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic run_case(input string nm, input int gap, input bit ed, input bit ee, input int el);
        int base;
        int end_cyc;
        bit got;
        bit md, me;
        int mld;
        base = wr_addr_q.size();
        end_cyc = -1;
        got = 1'b0;
        model(md, me, mld);
        foreach (prog_q[i])
            for (int b = 3; b >= 0; b--) send_byte(prog_q[i][8*b +: 8], gap);
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            s_if.in_valid = 1'b0;
            if (load_done === 1'b1 || load_error === 1'b1) begin
                got = 1'b1;
                end_cyc = cyc;
            end
        end
        #1;
        if (!got) timeout_fail({nm, " outcome"});
        check({nm, " load_done"}, load_done, ed);
        check({nm, " load_error"}, load_error, ee);
        check({nm, " cpu_reset"}, cpu_reset, !ed);
        check({nm, " in_ready"}, s_if.in_ready, 1'b0);
        check({nm, " words_loaded"}, words_loaded, el);
        check({nm, " write count"}, wr_addr_q.size() - base, exp_w.size());
        foreach (exp_w[i]) begin
            if (base + i < wr_addr_q.size()) begin
                check($sformatf("%s wr%0d addr", nm, i), wr_addr_q[base+i], i);
                check($sformatf("%s wr%0d data", nm, i), wr_data_q[base+i], exp_w[i]);
            end
        end
        // Last accepted byte's edge lands at last_acc+1; HOLD spans that cycle plus RESET_HOLD more.
        if (ed && got) check({nm, " release cycle"}, end_cyc, last_acc + RESET_HOLD + 2);
`ifndef LOADER_CHECKSUM_EN
        if (ed && got && exp_w.size() > 0 && wr_cyc_q.size() > 0)
            check({nm, " release after last write"}, end_cyc, wr_cyc_q[$] + RESET_HOLD + 1);
`endif
        if (gap == 0 && exp_w.size() > 1 && wr_cyc_q.size() >= base + exp_w.size())
            for (int i = 0; i + 1 < exp_w.size(); i++)
                check($sformatf("%s spacing%0d", nm, i), wr_cyc_q[base+i+1] - wr_cyc_q[base+i], 4);
        if (ee) begin
            repeat (3) @(negedge clk);
            check({nm, " err in_ready"}, s_if.in_ready, 1'b0);
            check({nm, " err cpu_reset"}, cpu_reset, 1'b1);
            check({nm, " err load_error"}, load_error, 1'b1);
        end
    endtask

    task automatic load_basic();
        prog_q.delete();
        prog_q.push_back(32'd3);
        prog_q.push_back(32'h20080005);
        prog_q.push_back(32'h20090007);
        prog_q.push_back(32'h01095020);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rd, re;
        int rl;
        int n_pre;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst cpu_reset", cpu_reset, 1'b1);
        check("rst load_done", load_done, 1'b0);
        check("rst load_error", load_error, 1'b0);
        check("rst words_loaded", words_loaded, 0);
        check("rst in_ready", s_if.in_ready, 1'b1);
        #1 reset = 1'b1;

        tbl[0] = mk(4, 32'd3, 32'h20080005, 32'h20090007, 32'h01095020, 0, 1, 0, 3);
        tbl[1] = mk(4, 32'd3, 32'h20080005, 32'h20090007, 32'h01095020, 40, 1, 0, 3);
        tbl[2] = mk(1, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0);
        tbl[3] = mk(1, 32'h00000101, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0);
        tbl[4] = mk(2, 32'd1, 32'hAC0A0032, 32'd0, 32'd0, 20, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) do_reset();
            prog_q.delete();
            for (int j = 0; j < tbl[i].nw; j++) prog_q.push_back(tbl[i].w[j]);
            add_trailer();
            run_case($sformatf("vec%0d", i), tbl[i].gap, tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_loaded);
        end

        // Reset after 6 bytes, then a full restart.
        do_reset();
        load_basic();
        n_pre = wr_addr_q.size();
        for (int k = 0; k < 6; k++) send_byte(prog_q[k/4][8*(3-(k%4)) +: 8], 0);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("midrst words_loaded", words_loaded, 0);
        check("midrst in_ready", s_if.in_ready, 1'b1);
        check("midrst cpu_reset", cpu_reset, 1'b1);
        check("midrst no early write", wr_addr_q.size(), n_pre);
        #1 reset = 1'b1;
        add_trailer();
        run_case("restart", 0, 1, 0, 3);

        // Reload in RUN with a byte offered the same cycle.
        @(negedge clk);
        reload = 1'b1;
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'hAA;
        @(negedge clk);
        reload = 1'b0;
        s_if.in_valid = 1'b0;
        check("reload cpu_reset", cpu_reset, 1'b1);
        check("reload load_done", load_done, 1'b0);
        check("reload words_loaded", words_loaded, 0);
        check("reload in_ready", s_if.in_ready, 1'b1);
        prog_q.delete();
        prog_q.push_back(32'd1);
        prog_q.push_back(32'hAC0A0032);
        add_trailer();
        run_case("reload_prog", 0, 1, 0, 1);

        // Oversized header, then recover via reload from ERR.
        pulse_reload();
        prog_q.delete();
        prog_q.push_back(32'h00000101);
        run_case("n257", 0, 0, 1, 0);
        pulse_reload();
        check("err reload load_error", load_error, 1'b0);
        check("err reload in_ready", s_if.in_ready, 1'b1);
        check("err reload cpu_reset", cpu_reset, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        load_basic();
        prog_q.push_back(32'h411A502F);
        run_case("csum_ok", 0, 1, 0, 3);
        pulse_reload();
        load_basic();
        prog_q.push_back(32'h411A5030);
        run_case("csum_bad", 0, 0, 1, 3);
`endif

        for (int it = 0; it < 8; it++) begin
            int n;
            pulse_reload();
            prog_q.delete();
            n = (it == 3) ? int'($urandom_range(1000, 257)) : int'($urandom_range(6, 0));
            prog_q.push_back(32'(n));
            if (n <= MEM_WORDS)
                for (int j = 0; j < n; j++) prog_q.push_back($urandom);
            add_trailer();
`ifdef LOADER_CHECKSUM_EN
            if (n <= MEM_WORDS && $urandom_range(2) == 0) prog_q[$] = prog_q[$] ^ 32'h1;
`endif
            model(rd, re, rl);
            run_case($sformatf("rnd%0d", it), int'($urandom_range(60)), rd, re, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
